coin_acceptor: RTL and testbench

Front-end conditioner between the three raw coin-sensor lines and the vending FSM's moneda input. It synchronises and debounces each sensor and converts each clean insertion into a single one-cycle moneda code (01 = 2, 10 = 3, 11 = 4). It arbitrates simultaneous coins, spaces its pulses, and holds coins pending while the downstream stage is not accepting.

---
 rtl/coin_acceptor.sv | 128 ++++++++++++
 tb/tb_coin_acceptor.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin-sensor front end: synchronises and debounces three raw coin lines and turns
// each clean insertion into one isolated, prioritised moneda pulse for the vending FSM.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MIN_GAP         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin2_raw,
  input  logic       coin3_raw,
  input  logic       coin4_raw,
  input  logic       accept_en,
  output logic [1:0] moneda,
  output logic [2:0] pending,
  output logic       coin_lost,
  output logic [1:0] dbg_state_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q, lvl_q;
  logic [CW-1:0] cnt_q [3];
  logic [2:0]    rise;

  state_t        state_q;
  logic [GW-1:0] gap_q;
  logic [2:0]    grant;
  logic [1:0]    code;
  logic [2:0]    pending_d;

  assign raw         = {coin4_raw, coin3_raw, coin2_raw};
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      lvl_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      for (int i = 0; i < 3; i++) begin
        if (s2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i] <= '0;
          lvl_q[i] <= ~lvl_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A rising event is the edge on which a low debounced level is about to toggle.
  always_comb begin
    rise = '0;
    for (int i = 0; i < 3; i++) begin
      rise[i] = !lvl_q[i] && s2_q[i] && (cnt_q[i] == CNT_LAST);
    end
  end

  // Handshake: accept_en is looked at only while IDLE; once a coin is selected its
  // one-cycle moneda pulse and the following quiet gap always run to completion.
  always_comb begin
    grant = '0;
    code  = 2'b00;
    if (state_q == IDLE && accept_en) begin
      if (pending[2]) begin
        grant = 3'b100;
        code  = 2'b11;
      end else if (pending[1]) begin
        grant = 3'b010;
        code  = 2'b10;
      end else if (pending[0]) begin
        grant = 3'b001;
        code  = 2'b01;
      end
    end
    pending_d = (pending & ~grant) | rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gap_q     <= '0;
      moneda    <= 2'b00;
      pending   <= 3'b000;
      coin_lost <= 1'b0;
    end else begin
      pending <= pending_d;
      if (|(rise & pending & ~grant)) coin_lost <= 1'b1;
      case (state_q)
        IDLE: begin
          moneda <= code;
          if (|grant) state_q <= EMIT;
        end
        EMIT: begin
          moneda  <= 2'b00;
          gap_q   <= GAP_LOAD;
          state_q <= (MIN_GAP == 1) ? IDLE : GAP;
        end
        GAP: begin
          // The IDLE cycle that follows supplies the last quiet cycle of the gap.
          moneda <= 2'b00;
          gap_q  <= gap_q - 1'b1;
          if (gap_q == GW'(1)) state_q <= IDLE;
        end
        default: begin
          moneda  <= 2'b00;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios plus random sensor traffic, all checked
// cycle by cycle against a behavioural model of the coin rules.
module tb_coin_acceptor;

  localparam int D = 4;
  localparam int G = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic c2 = 1'b0, c3 = 1'b0, c4 = 1'b0;
  logic accept_en = 1'b0;
  logic [1:0] moneda;
  logic [2:0] pending;
  logic       coin_lost;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .MIN_GAP(G)) dut (
    .clk(clk), .reset(reset),
    .coin2_raw(c2), .coin3_raw(c3), .coin4_raw(c4),
    .accept_en(accept_en),
    .moneda(moneda), .pending(pending), .coin_lost(coin_lost),
    .dbg_state_o(dbg_state)
  );

  // Reference model: raw samples reach the debouncer two edges late, a level flips
  // after D consecutive differing samples, and a coin may be emitted once G+1 edges
  // have passed since the previous emission.
  logic [2:0] raw_q[$];
  logic [2:0] m_lvl = '0;
  int         m_run [3] = '{0, 0, 0};
  logic [2:0] m_pend = '0;
  logic       m_lost = 1'b0;
  logic [1:0] m_moneda = '0;
  int         m_edge = 0;
  int         m_last = -100;

  always @(posedge clk or negedge reset) begin : model
    logic [2:0] syn, rise, grant, lvl_n;
    logic [1:0] code;
    if (!reset) begin
      raw_q.delete();
      raw_q.push_back(3'b000);
      raw_q.push_back(3'b000);
      m_lvl <= '0;
      for (int c = 0; c < 3; c++) m_run[c] <= 0;
      m_pend <= '0;
      m_lost <= 1'b0;
      m_moneda <= '0;
      m_edge <= 0;
      m_last <= -100;
    end else begin
      raw_q.push_back({c4, c3, c2});
      syn = raw_q.pop_front();
      grant = '0;
      code = 2'b00;
      if ((m_edge - m_last) >= G + 1 && accept_en && m_pend != 3'b000) begin
        for (int c = 2; c >= 0; c--) begin
          if (grant == 3'b000 && m_pend[c]) begin
            grant[c] = 1'b1;
            code = 2'(c + 1);
          end
        end
      end
      rise = '0;
      lvl_n = m_lvl;
      for (int c = 0; c < 3; c++) begin
        if (syn[c] != m_lvl[c]) begin
          if (m_run[c] + 1 == D) begin
            lvl_n[c] = syn[c];
            rise[c] = syn[c];
            m_run[c] <= 0;
          end else begin
            m_run[c] <= m_run[c] + 1;
          end
        end else begin
          m_run[c] <= 0;
        end
      end
      m_lvl <= lvl_n;
      if ((rise & m_pend & ~grant) != 3'b000) m_lost <= 1'b1;
      m_pend <= (m_pend & ~grant) | rise;
      m_moneda <= code;
      if (grant != 3'b000) m_last <= m_edge;
      m_edge <= m_edge + 1;
    end
  end

  task automatic test_reset();
    int first;
    int pulses;
    logic [1:0] first_code;
    #2;
    reset = 1'b0;
    accept_en = 1'b1;
    {c4, c3, c2} = 3'b111;
    repeat (8) begin
      @(negedge clk);
      n_cmp++;
      if ({moneda, pending, coin_lost} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_hold: got moneda=%b pending=%b lost=%b, want 00/000/0", moneda, pending, coin_lost);
      end
    end
    {c4, c3} = 2'b00;
    reset = 1'b1;
    first = -1;
    pulses = 0;
    first_code = 2'b00;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({moneda, pending, coin_lost} !== {m_moneda, m_pend, m_lost}) begin
        n_bad++;
        $display("FAIL reset_release k=%0d: got %b/%b/%b, want %b/%b/%b", k, moneda, pending, coin_lost, m_moneda, m_pend, m_lost);
      end
      if (moneda != 2'b00) begin
        pulses++;
        if (first < 0) begin
          first = k;
          first_code = moneda;
        end
      end
    end
    n_cmp++;
    if (pulses != 1 || first != D + 2 || first_code !== 2'b01) begin
      n_bad++;
      $display("FAIL reset_first_coin: got %0d pulses first at %0d code %b, want 1 at %0d code 01", pulses, first, first_code, D + 2);
    end
    c2 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_clean_coin3();
    int first;
    int pulses;
    c3 = 1'b1;
    first = -1;
    pulses = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({moneda, pending, coin_lost} !== {m_moneda, m_pend, m_lost}) begin
        n_bad++;
        $display("FAIL clean3 k=%0d: got %b/%b/%b, want %b/%b/%b", k, moneda, pending, coin_lost, m_moneda, m_pend, m_lost);
      end
      if (moneda != 2'b00) begin
        pulses++;
        if (first < 0) first = k;
        n_cmp++;
        if (moneda !== 2'b10) begin
          n_bad++;
          $display("FAIL clean3_code: got %b, want 10", moneda);
        end
      end
      if (k == 19) c3 = 1'b0;
    end
    n_cmp++;
    if (pulses != 1 || first != D + 2) begin
      n_bad++;
      $display("FAIL clean3_timing: got %0d pulses first at %0d, want 1 at %0d", pulses, first, D + 2);
    end
  endtask

  task automatic test_bounce();
    int first;
    int pulses;
    first = -1;
    pulses = 0;
    for (int i = 0; i < 26; i++) begin
      c2 = (i < 10) ? (((i / 2) % 2) == 0) : 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({moneda, pending, coin_lost} !== {m_moneda, m_pend, m_lost}) begin
        n_bad++;
        $display("FAIL bounce i=%0d: got %b/%b/%b, want %b/%b/%b", i, moneda, pending, coin_lost, m_moneda, m_pend, m_lost);
      end
      if (moneda != 2'b00) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    // The last high run starts at sample 8, so the level rises on edge 8+D+1.
    n_cmp++;
    if (pulses != 1 || first != 8 + D + 2) begin
      n_bad++;
      $display("FAIL bounce_timing: got %0d pulses first at %0d, want 1 at %0d", pulses, first, 8 + D + 2);
    end
    c2 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int zeros;
    int seen;
    logic [2:0] want_pend [4] = '{3'b111, 3'b011, 3'b001, 3'b000};
    int         pend_at   [4] = '{D + 1, D + 2, D + 3 + G, D + 4 + 2 * G};
    exp_q.delete();
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    {c4, c3, c2} = 3'b111;
    zeros = 0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({moneda, pending, coin_lost} !== {m_moneda, m_pend, m_lost}) begin
        n_bad++;
        $display("FAIL simul k=%0d: got %b/%b/%b, want %b/%b/%b", k, moneda, pending, coin_lost, m_moneda, m_pend, m_lost);
      end
      for (int j = 0; j < 4; j++) begin
        if (k == pend_at[j]) begin
          n_cmp++;
          if (pending !== want_pend[j]) begin
            n_bad++;
            $display("FAIL simul_pending k=%0d: got %b, want %b", k, pending, want_pend[j]);
          end
        end
      end
      if (moneda != 2'b00) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL simul_extra: got code %b, want none", moneda);
        end else if (moneda !== exp_q[0]) begin
          n_bad++;
          $display("FAIL simul_order: got %b, want %b", moneda, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (seen > 0) begin
          n_cmp++;
          if (zeros != G) begin
            n_bad++;
            $display("FAIL simul_gap: got %0d idle cycles, want %0d", zeros, G);
          end
        end
        seen++;
        zeros = 0;
      end else if (seen > 0) begin
        zeros++;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL simul_missing: got %0d codes unemitted, want 0", exp_q.size());
    end
    {c4, c3, c2} = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_holdoff();
    accept_en = 1'b0;
    c2 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({moneda, pending, coin_lost} !== {m_moneda, m_pend, m_lost} || moneda !== 2'b00) begin
        n_bad++;
        $display("FAIL holdoff k=%0d: got %b/%b/%b, want %b/%b/%b", k, moneda, pending, coin_lost, m_moneda, m_pend, m_lost);
      end
    end
    n_cmp++;
    if (pending !== 3'b001) begin
      n_bad++;
      $display("FAIL holdoff_pending: got %b, want 001", pending);
    end
    accept_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (moneda !== 2'b01 || pending !== 3'b000) begin
      n_bad++;
      $display("FAIL holdoff_release: got moneda=%b pending=%b, want 01/000", moneda, pending);
    end
    c2 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_same_edge();
    int pulses;
    accept_en = 1'b0;
    c2 = 1'b1;
    repeat (8) @(negedge clk);
    c2 = 1'b0;
    repeat (8) @(negedge clk);
    c2 = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({moneda, pending, coin_lost} !== {m_moneda, m_pend, m_lost}) begin
        n_bad++;
        $display("FAIL same_edge k=%0d: got %b/%b/%b, want %b/%b/%b", k, moneda, pending, coin_lost, m_moneda, m_pend, m_lost);
      end
      if (k == D + 1) begin
        n_cmp++;
        if (moneda !== 2'b01 || pending !== 3'b001 || coin_lost !== 1'b0) begin
          n_bad++;
          $display("FAIL same_edge_merge: got %b/%b/%b, want 01/001/0", moneda, pending, coin_lost);
        end
      end
      if (moneda != 2'b00) pulses++;
      if (k == D) accept_en = 1'b1;
    end
    n_cmp++;
    if (pulses != 2) begin
      n_bad++;
      $display("FAIL same_edge_pulses: got %0d, want 2", pulses);
    end
    c2 = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_loss();
    int pulses;
    accept_en = 1'b0;
    for (int k = 0; k < 30; k++) begin
      c4 = (k < 10 || k >= 20);
      @(negedge clk);
      n_cmp++;
      if ({moneda, pending, coin_lost} !== {m_moneda, m_pend, m_lost}) begin
        n_bad++;
        $display("FAIL loss k=%0d: got %b/%b/%b, want %b/%b/%b", k, moneda, pending, coin_lost, m_moneda, m_pend, m_lost);
      end
    end
    n_cmp++;
    if (pending !== 3'b100 || coin_lost !== 1'b1) begin
      n_bad++;
      $display("FAIL loss_flag: got pending=%b lost=%b, want 100/1", pending, coin_lost);
    end
    accept_en = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (coin_lost !== 1'b1 || (moneda != 2'b00 && moneda !== 2'b11)) begin
        n_bad++;
        $display("FAIL loss_emit k=%0d: got moneda=%b lost=%b, want 11-or-00/1", k, moneda, coin_lost);
      end
      if (moneda != 2'b00) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL loss_pulses: got %0d, want 1", pulses);
    end
    c4 = 1'b0;
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({moneda, pending, coin_lost} !== 6'b0) begin
      n_bad++;
      $display("FAIL async_reset: got %b/%b/%b, want 00/000/0", moneda, pending, coin_lost);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0] prev;
    prev = 2'b00;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 5) == 0) c2 = ~c2;
      if ($urandom_range(0, 5) == 0) c3 = ~c3;
      if ($urandom_range(0, 5) == 0) c4 = ~c4;
      if ($urandom_range(0, 9) == 0) accept_en = ~accept_en;
      @(negedge clk);
      n_cmp++;
      if ({moneda, pending, coin_lost} !== {m_moneda, m_pend, m_lost}) begin
        n_bad++;
        $display("FAIL random k=%0d: got %b/%b/%b, want %b/%b/%b", k, moneda, pending, coin_lost, m_moneda, m_pend, m_lost);
      end
      if (prev != 2'b00 && moneda != 2'b00) begin
        n_cmp++;
        n_bad++;
        $display("FAIL random_isolation k=%0d: got %b after %b, want 00", k, moneda, prev);
      end
      prev = moneda;
    end
  endtask

  initial begin
    test_reset();
    test_clean_coin3();
    test_bounce();
    test_simultaneous();
    test_holdoff();
    test_same_edge();
    test_loss();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
